// File: rtl/speed_meas_ctrl.sv
// Sequencer around one phase2speed datapath: gates the phase stream, applies meanlen
// changes through a datapath flush, and buffers each new speed result for a consumer.
module speed_meas_ctrl #(
    parameter int FLUSH_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_enable,
    input  logic [3:0]  i_cfg_meanlen,
    input  logic        i_cfg_write,
    input  logic [18:0] i_phase_in,
    input  logic        i_phase_valid,
    output logic        o_p2s_reset,
    output logic        o_p2s_sample,
    output logic [3:0]  o_p2s_meanlen,
    output logic [18:0] o_p2s_phase,
    input  logic [15:0] i_p2s_speed,
    input  logic        i_p2s_ready,
    output logic [15:0] o_speed_out,
    output logic        o_speed_valid,
    input  logic        i_speed_accept,
    output logic        o_overrun,
    output logic        o_stale,
    input  logic        i_clear_status,
    output logic        o_busy
);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, FLUSH, RUN} state_t;

    state_t      r_state, w_next;
    logic [FW-1:0] r_flush_cnt;
    logic [TW-1:0] r_to_cnt;
    logic [3:0]  r_pending;
    logic        r_discard;
    logic        r_ready_d;
    logic        w_flush_entry;
    logic        w_in_run;
    logic        w_capture;
    logic        w_transfer;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_enable) w_next = FLUSH;
            FLUSH:   if (r_flush_cnt == FW'(FLUSH_CYCLES - 1)) w_next = i_enable ? RUN : IDLE;
            RUN: begin
                if (!i_enable)        w_next = IDLE;
                else if (i_cfg_write) w_next = FLUSH;
            end
            default: w_next = IDLE;
        endcase
    end

    // Samples are forwarded only while the datapath stays out of reset next cycle,
    // so a strobe coinciding with a reconfig or disable is dropped.
    assign w_in_run      = (r_state == RUN) && (w_next == RUN);
    assign w_flush_entry = (w_next == FLUSH) && (r_state != FLUSH);
    assign w_capture     = i_p2s_ready && !r_ready_d && (r_state == RUN);
    assign w_transfer    = o_speed_valid && i_speed_accept;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            r_flush_cnt   <= '0;
            r_pending     <= '0;
            r_discard     <= 1'b1;
            r_ready_d     <= 1'b0;
            r_to_cnt      <= '0;
            o_p2s_sample  <= 1'b0;
            o_p2s_phase   <= '0;
            o_p2s_meanlen <= '0;
            o_speed_out   <= '0;
            o_speed_valid <= 1'b0;
            o_overrun     <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_ready_d <= i_p2s_ready;
            if (i_cfg_write) r_pending <= i_cfg_meanlen;

            if (w_flush_entry) begin
                r_flush_cnt   <= '0;
                o_p2s_meanlen <= i_cfg_write ? i_cfg_meanlen : r_pending;
            end else if (r_state == FLUSH) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end

            o_p2s_sample <= w_in_run && i_phase_valid;
            if (r_state == RUN) o_p2s_phase <= i_phase_in;

            if (!w_in_run || i_phase_valid)       r_to_cnt <= '0;
            else if (r_to_cnt != TW'(TIMEOUT_CYCLES)) r_to_cnt <= r_to_cnt + 1'b1;

            // First window after a flush is partial: drop its result.
            if (w_flush_entry) begin
                r_discard <= 1'b1;
            end else if (w_capture && r_discard) begin
                r_discard <= 1'b0;
            end

            if (w_capture && !r_discard) begin
                o_speed_out   <= i_p2s_speed;
                o_speed_valid <= 1'b1;
            end else if (w_transfer) begin
                o_speed_valid <= 1'b0;
            end

            if (w_capture && !r_discard && o_speed_valid && !i_speed_accept)
                o_overrun <= 1'b1;
            else if (i_clear_status)
                o_overrun <= 1'b0;
        end
    end

    assign o_p2s_reset = (r_state != RUN);
    assign o_stale     = (r_to_cnt == TW'(TIMEOUT_CYCLES));
    assign o_busy      = (r_state != IDLE);

endmodule
